uart_tx: RTL

// - UART transmitter, 8 data bits, LSB first, no parity (8N1) by default. Companion to the

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte-in handshake and serial-out bundle for uart_tx.
// master drives the byte side; slave is the transmitter.
interface uart_tx_if;
  logic       i_tx_dv;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready;
  logic       o_tx_active;
  logic       o_tx_serial;
  logic       o_tx_done;

  modport master (
    output i_tx_dv,
    output i_tx_byte,
    input  o_tx_ready,
    input  o_tx_active,
    input  o_tx_serial,
    input  o_tx_done
  );

  modport slave (
    input  i_tx_dv,
    input  i_tx_byte,
    output o_tx_ready,
    output o_tx_active,
    output o_tx_serial,
    output o_tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits, single-byte holding register.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd via PARITY_ODD) after bit 7.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : gen_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 4");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : gen_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StCleanup
`ifdef UART_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   clk_count_q, clk_count_d;
  logic [2:0]        bit_index_q, bit_index_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              serial_q, serial_d;
  logic              ready_q, ready_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              cnt_last;

  assign cnt_last = (clk_count_q == CntLast);

  // bit_index doubles as the stop-bit counter while in StStop.
  always_comb begin
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_index_d = bit_index_q;
    tx_shift_d  = tx_shift_q;

    case (state_q)
      StIdle: begin
        clk_count_d = '0;
        bit_index_d = '0;
        if (bus.i_tx_dv) begin
          state_d    = StStart;
          tx_shift_d = bus.i_tx_byte;
        end
      end
      StStart: begin
        if (cnt_last) begin
          clk_count_d = '0;
          bit_index_d = '0;
          state_d     = StData;
        end else begin
          clk_count_d = clk_count_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_last) begin
          clk_count_d = '0;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d     = StParity;
`else
            state_d     = StStop;
`endif
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + CntW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (cnt_last) begin
          clk_count_d = '0;
          bit_index_d = '0;
          state_d     = StStop;
        end else begin
          clk_count_d = clk_count_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (cnt_last) begin
          clk_count_d = '0;
          if (bit_index_q == StopLast) begin
            bit_index_d = '0;
            state_d     = StCleanup;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end else begin
          clk_count_d = clk_count_q + CntW'(1);
        end
      end
      StCleanup: begin
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        clk_count_d = '0;
        bit_index_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the line never glitches.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = tx_shift_d[bit_index_d];
`ifdef UART_TX_PARITY_EN
      StParity: serial_d = (PARITY_ODD != 0) ? ~^tx_shift_d : ^tx_shift_d;
`endif
      default:  serial_d = 1'b1;
    endcase
    ready_d  = (state_d == StIdle);
    done_d   = (state_d == StCleanup);
    active_d = (state_d != StIdle) && (state_d != StCleanup);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      clk_count_q <= '0;
      bit_index_q <= '0;
      tx_shift_q  <= '0;
      serial_q    <= 1'b1;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_index_q <= bit_index_d;
      tx_shift_q  <= tx_shift_d;
      serial_q    <= serial_d;
      ready_q     <= ready_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_tx_serial = serial_q;
  assign bus.o_tx_ready  = ready_q;
  assign bus.o_tx_active = active_q;
  assign bus.o_tx_done   = done_q;

endmodule
